// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchronizer for one asynchronous pin, with an extra
// history flop so single-cycle rise/fall pulses come out of registered state.
//   clk, resetq : system clock, async active-low reset
//   d           : raw asynchronous input
//   q           : synchronized level
//   rise, fall  : one-clk pulses on synchronized edges
// STAGES must be >= 2.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetq,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sh;
  logic              hist;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sh   <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sh   <= {sh[STAGES-2:0], d};
      hist <= sh[STAGES-1];
    end
  end

  assign q    = sh[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;
endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 slave with a byte-wide CPU interface.
//   clk, resetq      : system clock, async active-low reset
//   sclk, ssb, mosi  : SPI pins from the external master (asynchronous)
//   miso, miso_oe    : slave data out and its output enable (high while selected)
//   wr, tx_data      : CPU loads the tx holding register
//   rd               : CPU acknowledges the received byte
//   rx_data          : last complete received byte
//   status           : {selected, overrun, tx_full, valid}
// A "load point" (select, or the 8th sclk rise) moves tx_hold (or FILL_BYTE)
// into the shifter and puts its MSB on miso one cycle after detection.
module spi_responder #(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sclk,
  input  logic       ssb,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic [3:0] status
);
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ssb_lvl_unused, ssb_rise, ssb_fall;
  logic [SYNC_STAGES-1:0] mosi_sh;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .resetq(resetq), .d(sclk),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssb (
    .clk(clk), .resetq(resetq), .d(ssb),
    .q(ssb_lvl_unused), .rise(ssb_rise), .fall(ssb_fall)
  );

  // mosi is only ever sampled as a level, so no edge detect.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) mosi_sh <= '0;
    else         mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sh[SYNC_STAGES-1];

  logic [7:0] rx_shift, tx_shift, tx_hold, rx_q;
  logic [2:0] bit_cnt;
  logic       sel, valid, overrun, tx_full, skip_fall, miso_q, oe_q;
  logic       byte_done, load_pt;
  logic [7:0] load_byte;

  // Select edges take priority over sclk edges in the same cycle.
  assign byte_done = sel & sclk_rise & ~ssb_fall & ~ssb_rise & (bit_cnt == 3'd7);
  assign load_pt   = ssb_fall | byte_done;
  assign load_byte = tx_full ? tx_hold : FILL_BYTE;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
      rx_q      <= '0;
      bit_cnt   <= '0;
      sel       <= 1'b0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      tx_full   <= 1'b0;
      skip_fall <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      // Later assignments win: completion beats rd, wr beats the load's clear.
      if (rd) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (load_pt) begin
        tx_shift <= load_byte;
        miso_q   <= load_byte[7];
        tx_full  <= 1'b0;
      end
      if (wr) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end

      if (ssb_fall) begin
        bit_cnt   <= '0;
        oe_q      <= 1'b1;
        sel       <= 1'b1;
        skip_fall <= 1'b0;
      end else if (sel && ssb_rise) begin
        // Partial byte and shifter contents are dropped; tx_hold is kept.
        bit_cnt   <= '0;
        oe_q      <= 1'b0;
        miso_q    <= 1'b0;
        sel       <= 1'b0;
        skip_fall <= 1'b0;
        tx_shift  <= '0;
      end else if (sel && sclk_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          rx_q      <= {rx_shift[6:0], mosi_s};
          if (valid) overrun <= 1'b1;
          valid     <= 1'b1;
          bit_cnt   <= '0;
          // The load point already placed the next MSB; the next fall must not shift it away.
          skip_fall <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (sel && sclk_fall) begin
        if (skip_fall) begin
          skip_fall <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          miso_q   <= tx_shift[6];
        end
      end
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign rx_data = rx_q;
  assign status  = {sel, overrun, tx_full, valid};
endmodule

// File: tb/tb_spi_responder.sv
`timescale 1ns/1ps
module tb_spi_responder;
  localparam int HALF = 6;

  logic clk = 1'b0, resetq = 1'b0;
  logic sclk = 1'b0, ssb = 1'b1, mosi = 1'b0;
  logic wr = 1'b0, rd = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic [3:0] status;
  logic       miso2, oe2_unused;
  logic [7:0] rx2_unused;
  logic [3:0] st2_unused;

  always #5 clk = ~clk;

  spi_responder dut (
    .clk(clk), .resetq(resetq), .sclk(sclk), .ssb(ssb), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wr(wr), .rd(rd), .tx_data(tx_data),
    .rx_data(rx_data), .status(status)
  );

  // Second responder with a zero fill byte and no CPU writes: always sends 00.
  spi_responder #(.FILL_BYTE(8'h00)) dut_fill0 (
    .clk(clk), .resetq(resetq), .sclk(sclk), .ssb(ssb), .mosi(mosi),
    .miso(miso2), .miso_oe(oe2_unused), .wr(1'b0), .rd(1'b1), .tx_data(8'h00),
    .rx_data(rx2_unused), .status(st2_unused)
  );

  int total = 0, bad = 0;
  logic [7:0] exp_miso[$], obs_miso[$], exp_rx[$];

  // Reference model: what the CPU and master should observe.
  logic       m_pend = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_hold = 8'h00, m_rx = 8'h00;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_load(output logic [7:0] b);
    b = m_pend ? m_hold : 8'hFF;
    m_pend = 1'b0;
  endtask

  task automatic m_complete(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_rx = b;
    exp_rx.push_back(b);
  endtask

  task automatic cpu_wr(input logic [7:0] v);
    @(negedge clk);
    tx_data = v; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    m_hold = v; m_pend = 1'b1;
  endtask

  task automatic cpu_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // One select period of up to 3 bytes. The last byte may be cut short
  // (last_bits < 8), optionally by a reset instead of deselect. col_idx picks
  // a byte whose 8th rise collides with a CPU write of col_val; pre_en writes
  // pre_val right after select.
  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int nbytes, input int last_bits, input int col_idx,
                      input logic [7:0] col_val, input bit pre_en,
                      input logic [7:0] pre_val, input bit do_reset);
    logic [7:0] bytes [3];
    logic [7:0] got, got2, cur;
    int nb;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    @(negedge clk);
    ssb = 1'b0;
    m_load(cur);
    ticks(HALF);
    if (pre_en) cpu_wr(pre_val);
    for (int k = 0; k < nbytes; k++) begin
      nb = (k == nbytes - 1) ? last_bits : 8;
      if (nb == 8) exp_miso.push_back(cur);
      got = 8'h00; got2 = 8'h00;
      for (int i = 0; i < nb; i++) begin
        mosi = bytes[k][7-i];
        ticks(HALF);
        got  = {got[6:0], miso};
        got2 = {got2[6:0], miso2};
        if (i == 7) begin
          m_complete(bytes[k]);
          m_load(cur);
        end
        sclk = 1'b1;
        if (k == col_idx && i == 7) begin
          // Rise is acted on 3 posedges after the pin edge; wr lands on that edge.
          ticks(2);
          tx_data = col_val; wr = 1'b1;
          ticks(1);
          wr = 1'b0;
          m_hold = col_val; m_pend = 1'b1;
          ticks(HALF - 3);
        end else begin
          ticks(HALF);
        end
        sclk = 1'b0;
      end
      if (nb == 8) begin
        obs_miso.push_back(got);
        check("fill00_miso", {24'h0, got2}, 32'h00);
      end
    end
    if (do_reset) begin
      resetq = 1'b0;
      #1;
      check("rst_mid_miso", {31'h0, miso}, 32'h0);
      check("rst_mid_oe", {31'h0, miso_oe}, 32'h0);
      check("rst_mid_rx", {24'h0, rx_data}, 32'h0);
      check("rst_mid_status", {28'h0, status}, 32'h0);
      m_pend = 1'b0; m_hold = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_rx = 8'h00;
      ssb = 1'b1; mosi = 1'b0;
      ticks(3);
      resetq = 1'b1;
      ticks(4);
    end else begin
      ticks(HALF);
      ssb = 1'b1; mosi = 1'b0;
      ticks(8);
    end
  endtask

  task automatic xfer1(input logic [7:0] b);
    xfer(b, 8'h00, 8'h00, 1, 8, -1, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic [3:0] m_status(input logic s);
    return {s, m_ovr, m_pend, m_valid};
  endfunction

  // Monitor: compares every completed rx byte and every master-observed miso byte.
  initial begin
    logic pv;
    logic [7:0] pr, e, o;
    pv = 1'b0; pr = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetq) begin
        pv = 1'b0; pr = 8'h00;
      end else begin
        if ((status[0] && !pv) || rx_data != pr) begin
          if (exp_rx.size() == 0) begin
            total++; bad++;
            $display("FAIL rx_unexpected got=%0h expected=none", rx_data);
          end else begin
            e = exp_rx.pop_front();
            check("rx_data", {24'h0, rx_data}, {24'h0, e});
            check("rx_valid", {31'h0, status[0]}, 32'h1);
          end
        end
        pv = status[0]; pr = rx_data;
        while (exp_miso.size() > 0 && obs_miso.size() > 0) begin
          o = obs_miso.pop_front();
          e = exp_miso.pop_front();
          check("miso_byte", {24'h0, o}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    #3ms;
    bad++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [7:0] dummy, prev, rb [3];
    int n, col;
    ticks(2);
    check("reset_miso", {31'h0, miso}, 32'h0);
    check("reset_oe", {31'h0, miso_oe}, 32'h0);
    check("reset_rx", {24'h0, rx_data}, 32'h0);
    check("reset_status", {28'h0, status}, 32'h0);
    resetq = 1'b1;
    ticks(5);

    // Byte exchange
    cpu_wr(8'hA5);
    check("tx_full_set", {28'h0, status}, {28'h0, m_status(1'b0)});
    xfer1(8'h3C);
    ticks(2);
    check("exchange_status", {28'h0, status}, {28'h0, m_status(1'b0)});
    cpu_rd();

    // Fill byte
    xfer1(8'h81);
    cpu_rd();

    // Overrun, then peek at status while selected
    xfer1(8'h11);
    xfer1(8'h22);
    check("overrun_rx", {24'h0, rx_data}, {24'h0, m_rx});
    @(negedge clk);
    ssb = 1'b0;
    m_load(dummy);
    ticks(8);
    check("overrun_status_sel", {28'h0, status}, {28'h0, m_status(1'b1)});
    check("overrun_oe", {31'h0, miso_oe}, 32'h1);
    ssb = 1'b1;
    ticks(8);
    cpu_rd();
    ticks(2);
    check("rd_clears", {28'h0, status}, {28'h0, m_status(1'b0)});

    // Abort after 5 bits; pending byte is consumed by that select
    cpu_wr(8'h33);
    xfer(8'hF0, 8'h00, 8'h00, 1, 5, -1, 8'h00, 1'b0, 8'h00, 1'b0);
    check("abort_oe", {31'h0, miso_oe}, 32'h0);
    check("abort_rx", {24'h0, rx_data}, {24'h0, m_rx});
    check("abort_status", {28'h0, status}, {28'h0, m_status(1'b0)});
    xfer1(8'h5A);
    cpu_rd();

    // Collision: 12 pending at the first 8th rise, 77 written on that same clk
    xfer(8'h01, 8'h02, 8'h04, 3, 8, 0, 8'h77, 1'b1, 8'h12, 1'b0);
    cpu_rd();

    // Reset mid-transfer, then a clean transfer
    xfer(8'h96, 8'h00, 8'h00, 1, 3, -1, 8'h00, 1'b0, 8'h00, 1'b1);
    xfer1(8'hC3);
    cpu_rd();

    // Randomized transfers
    prev = m_rx;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1, 0) == 1) cpu_wr(8'($urandom));
      n = $urandom_range(3, 1);
      for (int j = 0; j < 3; j++) begin
        rb[j] = 8'($urandom);
        if (rb[j] == prev) rb[j] = ~rb[j];
        prev = rb[j];
      end
      col = $urandom_range(3, 0);
      if (col >= n) col = -1;
      xfer(rb[0], rb[1], rb[2], n, 8, col, 8'($urandom),
           1'($urandom_range(1, 0)), 8'($urandom), 1'b0);
      prev = rb[n-1];
      if ($urandom_range(1, 0) == 1) begin
        cpu_rd();
      end
    end

    ticks(20);
    check("rx_queue_drained", exp_rx.size(), 32'h0);
    check("miso_queue_drained", exp_miso.size() + obs_miso.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
SPI slave peripheral for the j1 IO space. An external SPI master (host MCU or a second board) clocks bytes in and out; the CPU sees a buart-style byte interface (wr/rd strobes, valid/busy-like flags). It is the responder to the bit-banged SPI master the firmware already drives on SPICLK/SPISI/SPISSB. It is instantiated in top next to the uart, and decoded at its own IO addresses.

Parameters:
FILL_BYTE, 8'hFF, byte shifted out when no CPU tx byte is pending at a load point
SYNC_STAGES, 2, synchronizer depth for sclk, ssb and mosi (minimum 2)

Ports:
clk  input  1  system clock, all logic on posedge
resetq  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from external master, mode 0 (CPOL=0, CPHA=0)
ssb  input  1  SPI select, active low
mosi  input  1  master-out data
miso  output  1  slave-out data
miso_oe  output  1  1 while selected; drives SB_IO OUTPUT_ENABLE
wr  input  1  CPU io_wr strobe, decoded; loads tx_data into the tx holding register
rd  input  1  CPU io_rd strobe, decoded; acknowledges rx byte
tx_data  input  8  byte to send (dout[7:0])
rx_data  output  8  last complete received byte
status  output  4  {selected, overrun, tx_full, valid}

Behaviour:
- Reset (resetq low, async): shift regs 0, bit_cnt 0, rx_data 0, valid 0, overrun 0, tx_full 0, tx_hold 0, miso 0, miso_oe 0, synchronizers to idle (sclk 0, ssb 1, mosi 0).
- sclk, ssb, mosi pass through SYNC_STAGES flops plus one history flop for edge detect; all protocol actions use synchronized signals only.
- Timing contract: sclk high and low each >= 4 clk periods; master waits >= 4 clk after ssb falls before first sclk rise. Violations are undefined.
- Load point (ssb falling edge, or 8th sclk rise while selected): tx_shift <= tx_full ? tx_hold : FILL_BYTE; tx_full <= 0; miso <= MSB of loaded byte in the cycle after detection.
- ssb fall: bit_cnt <= 0, miso_oe <= 1, selected <= 1. MISO MSB valid SYNC_STAGES+1 clk after the pin edge.
- sclk rise while selected: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt++.
- On 8th rise: rx_data <= completed byte; if valid already 1 then overrun <= 1; valid <= 1; bit_cnt <= 0; perform load point. MSB first.
- sclk fall while selected: tx_shift shifts left, miso <= next bit. Suppressed on the fall following the 8th rise, since the load point has already placed the new MSB.
- ssb rise: partial byte discarded (rx_data, valid untouched), bit_cnt <= 0, miso_oe <= 0, miso <= 0, selected <= 0. tx_shift contents are dropped; a tx_hold still pending stays pending.
- sclk edges while ssb high are ignored.
- wr: tx_hold <= tx_data, tx_full <= 1. A wr while tx_full = 1 overwrites tx_hold (last write wins). If wr coincides with a load point, the load takes the old tx_hold/FILL, and the new byte lands in tx_hold with tx_full = 1.
- rd: valid <= 0, overrun <= 0. If rd coincides with byte completion, completion wins: valid = 1, rx_data = new byte, and overrun is set only if valid was 1 before that cycle.
- status and rx_data are registered, with no combinational path from pins.

Decomposition:
- No package. FILL_BYTE and SYNC_STAGES stay parameters, and the IO address defines stay in top.
- One sub-module, spi_sync_edge: an N-stage synchronizer with rise/fall pulse outputs, instantiated for sclk and ssb. mosi uses the level output only.

Test Plan:
- Byte exchange: CPU wr 8'hA5, then master selects and sends 8'h3C with sclk half-period 6 clk -> master reads 8'hA5 on miso, rx_data = 8'h3C, status valid = 1, tx_full = 0.
- Fill: no wr, master sends 8'h81 -> master reads 8'hFF; with FILL_BYTE = 8'h00 overridden, it reads 8'h00.
- Overrun: master sends 8'h11 then 8'h22 without rd -> rx_data = 8'h22, status = 4'b1101 while selected. A single rd -> valid = 0, overrun = 0.
- Abort: ssb rises after 5 bits of 8'hF0 -> rx_data unchanged, valid unchanged, miso_oe = 0. The next full transfer of 8'h5A -> rx_data = 8'h5A.
- Collision: wr 8'h77 in the same clk as the 8th sclk rise of the first byte, with tx_hold = 8'h12 pending -> second byte out = 8'h12, then 8'h77 on the third byte.
- Reset mid-transfer: resetq low after 3 bits -> all outputs at reset values immediately. After release, a fresh transfer of 8'hC3 is received correctly.
